systolic_seq_ctrl: RTL and testbench

Sequencer for one matrix-multiply pass of the dim_p x dim_p systolic PE array.
- Accepts a start command carrying inner dimension K.
- Clears the PE accumulators, steps K operand columns into the skewed array edges, then flushes the pipeline.
- Drains result rows to a downstream consumer under a valid/yumi handshake.
- Sits between the top-level command interface and the PE array / operand buffers.

---
 rtl/systolic_seq_ctrl.sv | 106 ++++++++++
 tb/tb_systolic_seq_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/systolic_seq_ctrl.sv
// systolic_seq_ctrl: sequencer for one clear/feed/flush/drain pass of a dim_p x dim_p systolic array.
// Optional abort input enabled by defining SYSTOLIC_SEQ_CTRL_ABORT_EN.
module systolic_seq_ctrl #(
  parameter int dim_p = 4,
  parameter int k_width_p = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic                     start_v_i,
  input  logic [k_width_p-1:0]     k_i,
`ifdef SYSTOLIC_SEQ_CTRL_ABORT_EN
  input  logic                     abort_i,
`endif
  output logic                     ready_o,
  output logic                     acc_clear_o,
  output logic                     step_o,
  output logic                     feed_v_o,
  output logic [k_width_p-1:0]     feed_idx_o,
  output logic                     result_v_o,
  output logic [$clog2(dim_p)-1:0] drain_row_o,
  input  logic                     result_yumi_i,
  output logic                     busy_o,
  output logic                     done_o
);
  localparam int flush_n = 2 * (dim_p - 1);
  localparam int fw = $clog2(flush_n);
  localparam int rw = $clog2(dim_p);
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, FLUSH, DRAIN, DONE} state_e;
  state_e state_r, state_n;
  logic [k_width_p-1:0] k_r, k_n, idx_r, idx_n;
  logic [fw-1:0] fl_r, fl_n;
  logic [rw-1:0] row_r, row_n;
  logic abort;
`ifdef SYSTOLIC_SEQ_CTRL_ABORT_EN
  assign abort = abort_i && (state_r != IDLE);
`else
  assign abort = 1'b0;
`endif
  assign feed_idx_o = idx_r;
  assign drain_row_o = row_r;
  // next-state and counter update; abort returns everything to the idle image
  always_comb begin
    state_n = state_r;
    k_n = k_r;
    idx_n = idx_r;
    fl_n = fl_r;
    row_n = row_r;
    case (state_r)
      IDLE: begin
        k_n = start_v_i ? k_i : k_r;
        state_n = start_v_i ? CLEAR : IDLE;
      end
      CLEAR: state_n = (k_r != '0) ? FEED : FLUSH;
      FEED: begin
        idx_n = (idx_r == k_r - k_width_p'(1)) ? '0 : idx_r + k_width_p'(1);
        state_n = (idx_r == k_r - k_width_p'(1)) ? FLUSH : FEED;
      end
      FLUSH: begin
        fl_n = (fl_r == fw'(flush_n - 1)) ? '0 : fl_r + fw'(1);
        state_n = (fl_r == fw'(flush_n - 1)) ? DRAIN : FLUSH;
      end
      DRAIN: begin
        row_n = !result_yumi_i ? row_r : (row_r == rw'(dim_p - 1)) ? '0 : row_r + rw'(1);
        state_n = (result_yumi_i && row_r == rw'(dim_p - 1)) ? DONE : DRAIN;
      end
      default: state_n = IDLE;
    endcase
    if (abort) begin
      state_n = IDLE;
      k_n = '0;
      idx_n = '0;
      fl_n = '0;
      row_n = '0;
    end
  end
  // state, counters and strobes registered from the next state so outputs never see inputs combinationally
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_r <= IDLE;
      k_r <= '0;
      idx_r <= '0;
      fl_r <= '0;
      row_r <= '0;
      ready_o <= 1'b1;
      acc_clear_o <= 1'b0;
      step_o <= 1'b0;
      feed_v_o <= 1'b0;
      result_v_o <= 1'b0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      state_r <= state_n;
      k_r <= k_n;
      idx_r <= idx_n;
      fl_r <= fl_n;
      row_r <= row_n;
      ready_o <= state_n == IDLE;
      acc_clear_o <= state_n == CLEAR;
      step_o <= state_n == FEED || state_n == FLUSH;
      feed_v_o <= state_n == FEED;
      result_v_o <= state_n == DRAIN;
      busy_o <= state_n != IDLE;
      done_o <= state_n == DONE;
    end
  end
endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// tb_systolic_seq_ctrl: directed scoreboard bench for systolic_seq_ctrl (dim_p=4, k_width_p=8).
module tb_systolic_seq_ctrl;
  logic clk_i, reset_ni, start_v_i, result_yumi_i, abort_i;
  logic [7:0] k_i, feed_idx_o;
  logic [1:0] drain_row_o;
  logic ready_o, acc_clear_o, step_o, feed_v_o, result_v_o, busy_o, done_o;
  int total = 0;
  int fails = 0;

  typedef struct {
    logic start;
    logic [7:0] k;
    logic yumi;
    logic abort;
    logic [16:0] exp;
    string tag;
  } entry_t;
  entry_t q[$];

  systolic_seq_ctrl #(.dim_p(4), .k_width_p(8)) dut (
    .clk_i(clk_i),
    .reset_ni(reset_ni),
    .start_v_i(start_v_i),
    .k_i(k_i),
`ifdef SYSTOLIC_SEQ_CTRL_ABORT_EN
    .abort_i(abort_i),
`endif
    .ready_o(ready_o),
    .acc_clear_o(acc_clear_o),
    .step_o(step_o),
    .feed_v_o(feed_v_o),
    .feed_idx_o(feed_idx_o),
    .result_v_o(result_v_o),
    .drain_row_o(drain_row_o),
    .result_yumi_i(result_yumi_i),
    .busy_o(busy_o),
    .done_o(done_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic logic [16:0] o(input logic rdy, input logic clr, input logic stp, input logic fv,
                                    input logic [7:0] idx, input logic rv, input logic [1:0] row,
                                    input logic bsy, input logic dn);
    return {rdy, clr, stp, fv, idx, rv, row, bsy, dn};
  endfunction

  function automatic logic [16:0] v_idle();  return o(1, 0, 0, 0, 8'd0, 0, 2'd0, 0, 0); endfunction
  function automatic logic [16:0] v_clear(); return o(0, 1, 0, 0, 8'd0, 0, 2'd0, 1, 0); endfunction
  function automatic logic [16:0] v_flush(); return o(0, 0, 1, 0, 8'd0, 0, 2'd0, 1, 0); endfunction
  function automatic logic [16:0] v_done();  return o(0, 0, 0, 0, 8'd0, 0, 2'd0, 1, 1); endfunction
  function automatic logic [16:0] v_feed(input int i);  return o(0, 0, 1, 1, 8'(i), 0, 2'd0, 1, 0); endfunction
  function automatic logic [16:0] v_drain(input int r); return o(0, 0, 0, 0, 8'd0, 1, 2'(r), 1, 0); endfunction

  function automatic logic [16:0] obs();
    return {ready_o, acc_clear_o, step_o, feed_v_o, feed_idx_o, result_v_o, drain_row_o, busy_o, done_o};
  endfunction

  task automatic check(input logic [16:0] e, input string tag);
    total++;
    assert (obs() === e) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs(), e);
    end
  endtask

  task automatic push(input logic s, input logic [7:0] k, input logic y, input logic ab,
                      input logic [16:0] e, input string t);
    entry_t en;
    en.start = s;
    en.k = k;
    en.yumi = y;
    en.abort = ab;
    en.exp = e;
    en.tag = t;
    q.push_back(en);
  endtask

  task automatic push_idle(input int n, input logic y);
    for (int i = 0; i < n; i++) push(0, 8'd0, y, 0, v_idle(), "idle");
  endtask

  // mode 0: yumi tied high; mode 1: yumi low then high for each row. hold keeps start_v_i high with random k_i.
  task automatic push_pass(input int k, input int mode, input logic hold);
    logic y0;
    y0 = (mode == 0);
    push(1, 8'(k), y0, 0, v_idle(), "accept");
    push(hold, 8'($urandom_range(1, 255)), y0, 0, v_clear(), "clear");
    for (int i = 0; i < k; i++) push(hold, 8'($urandom_range(0, 255)), y0, 0, v_feed(i), "feed");
    for (int i = 0; i < 6; i++) push(hold, 8'($urandom_range(0, 255)), y0, 0, v_flush(), "flush");
    for (int r = 0; r < 4; r++) begin
      if (mode == 1) push(hold, 8'd9, 0, 0, v_drain(r), "drain_wait");
      push(hold, 8'd9, 1, 0, v_drain(r), "drain");
    end
    push(hold, 8'd9, y0, 0, v_done(), "done");
  endtask

  task automatic run_q();
    entry_t en;
    while (q.size() > 0) begin
      en = q.pop_front();
      @(posedge clk_i);
      #1;
      start_v_i = en.start;
      k_i = en.k;
      result_yumi_i = en.yumi;
      abort_i = en.abort;
      @(negedge clk_i);
      check(en.exp, en.tag);
    end
  endtask

  initial begin
    reset_ni = 1'b0;
    start_v_i = 1'b0;
    k_i = 8'd0;
    result_yumi_i = 1'b0;
    abort_i = 1'b0;
    repeat (3) begin
      @(negedge clk_i);
      check(v_idle(), "in_reset");
    end
    @(posedge clk_i);
    #1 reset_ni = 1'b1;
    push_idle(10, 0);
    run_q();
    push_pass(3, 0, 0);
    push_idle(2, 1);
    push_pass(3, 1, 0);
    push_idle(2, 0);
    push_pass(0, 0, 0);
    push_idle(1, 0);
    push_pass(255, 0, 0);
    push_idle(1, 0);
    push_pass(5, 0, 1);
    push_pass(2, 0, 0);
    push_idle(2, 0);
    run_q();
    push(1, 8'd6, 0, 0, v_idle(), "accept");
    push(0, 8'd0, 0, 0, v_clear(), "clear");
    push(0, 8'd0, 0, 0, v_feed(0), "feed");
    push(0, 8'd0, 0, 0, v_feed(1), "feed");
    run_q();
    #2 reset_ni = 1'b0;
    #1 check(v_idle(), "async_reset");
    @(posedge clk_i);
    #1 reset_ni = 1'b1;
    push_idle(12, 1);
    push_pass(1, 0, 0);
    push_idle(1, 0);
    run_q();
`ifdef SYSTOLIC_SEQ_CTRL_ABORT_EN
    push(1, 8'd1, 0, 0, v_idle(), "accept");
    push(0, 8'd0, 0, 0, v_clear(), "clear");
    push(0, 8'd0, 0, 0, v_feed(0), "feed");
    push(0, 8'd0, 0, 0, v_flush(), "flush");
    push(0, 8'd0, 0, 1, v_flush(), "flush_abort");
    push(0, 8'd0, 0, 0, v_idle(), "after_abort");
    push_idle(3, 0);
    push(0, 8'd0, 0, 1, v_idle(), "idle_abort");
    push_idle(2, 0);
    push_pass(2, 0, 0);
    push_idle(2, 0);
    run_q();
`endif
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
